// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared word, RAM state and arbiter state types
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector starting the search at ptr
module rr_pick #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx
);
  logic [W-1:0] j;
  always_comb begin
    onehot = '0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = ptr + W'(k);
      if (req[j]) begin
        idx = j;
        onehot = '0;
        onehot[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port among CPUS cores, data before instruction, round-robin per class
module mem_arbiter import cpu_types_pkg::*; #(
  parameter int CPUS = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  word_t [CPUS-1:0]     iaddr,
  output logic [CPUS-1:0]      iwait,
  output word_t [CPUS-1:0]     iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  word_t [CPUS-1:0]     daddr,
  input  word_t [CPUS-1:0]     dstore,
  output logic [CPUS-1:0]      dwait,
  output word_t [CPUS-1:0]     dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate
);
  localparam int W = $clog2(CPUS);
  arb_state_t state_q, state_d;
  logic [W-1:0] core_q, core_d, iptr_q, iptr_d, dptr_q, dptr_d, d_idx, i_idx;
  logic data_q, data_d, gnt, live, ack;
  logic [CPUS-1:0] d_req, d_oh, i_oh;
  assign d_req = dREN | dWEN;
  rr_pick #(.N(CPUS)) u_dpick (.req(d_req), .ptr(dptr_q), .onehot(d_oh), .idx(d_idx));
  rr_pick #(.N(CPUS)) u_ipick (.req(iREN), .ptr(iptr_q), .onehot(i_oh), .idx(i_idx));
  always_comb begin
    gnt = state_q == GRANT;
    live = gnt && (data_q ? d_req[core_q] : iREN[core_q]);
    ack = live && ramstate == ACCESS;
    ramWEN = live && data_q && dWEN[core_q];
    ramREN = live && !ramWEN;
    ramaddr = !live ? '0 : data_q ? daddr[core_q] : iaddr[core_q];
    ramstore = (live && data_q) ? dstore[core_q] : '0;
    dwait = ~(CPUS'(ack && data_q) << core_q);
    iwait = ~(CPUS'(ack && !data_q) << core_q);
    iload = {CPUS{ramload}};
    dload = {CPUS{ramload}};
    state_d = state_q;
    core_d = core_q;
    data_d = data_q;
    iptr_d = (ack && !data_q) ? core_q + W'(1) : iptr_q;
    dptr_d = (ack && data_q) ? core_q + W'(1) : dptr_q;
    if (!gnt && (|d_oh || |i_oh)) begin
      state_d = GRANT;
      data_d = |d_oh;
      core_d = |d_oh ? d_idx : i_idx;
    end else if (gnt && (!live || ramstate == ACCESS || ramstate == ERROR)) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      core_q <= '0;
      data_q <= 1'b0;
      iptr_q <= '0;
      dptr_q <= '0;
    end else begin
      state_q <= state_d;
      core_q <= core_d;
      data_q <= data_d;
      iptr_q <= iptr_d;
      dptr_q <= dptr_d;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for the memory arbiter
module tb_mem_arbiter;
  import cpu_types_pkg::*;
  localparam word_t KEY = 32'h5A5A_0000;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic [1:0] iREN = '0, dREN = '0, dWEN = '0;
  word_t [1:0] iaddr = '0, daddr = '0, dstore = '0;
  logic [1:0] iwait, dwait;
  word_t [1:0] iload, dload;
  logic ramREN, ramWEN;
  word_t ramaddr, ramstore, ramload;
  ramstate_t ramstate;
  int ram_mode = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int core;
    bit is_data;
    bit we;
    word_t addr;
    word_t store;
  } exp_t;
  exp_t sbq[$];
  mem_arbiter #(.CPUS(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );
  always #5 CLK = ~CLK;
  assign ramload = ramaddr ^ KEY;
  always_comb ramstate = !(ramREN || ramWEN) ? FREE : ram_mode == 0 ? ACCESS : ram_mode == 1 ? BUSY : ERROR;
  task automatic cmp(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual %h required %h", n, a, e);
    end
  endtask
  task automatic push(int c, bit d, bit w, word_t a, word_t s);
    exp_t e;
    e.core = c;
    e.is_data = d;
    e.we = w;
    e.addr = a;
    e.store = s;
    sbq.push_back(e);
  endtask
  task automatic got_ack(int c, bit d);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack actual core %0d data %0d required none", c, d);
    end else begin
      e = sbq.pop_front();
      cmp("ack_core", c, e.core);
      cmp("ack_class", 32'(d), 32'(e.is_data));
      cmp("ack_ramWEN", 32'(ramWEN), 32'(e.we));
      cmp("ack_ramREN", 32'(ramREN), 32'(!e.we));
      cmp("ack_ramaddr", ramaddr, e.addr);
      if (e.we) cmp("ack_ramstore", ramstore, e.store);
      cmp("ack_load", d ? dload[c] : iload[c], e.addr ^ KEY);
    end
  endtask
  always @(negedge CLK) begin
    if (nRST) begin
      for (int c = 0; c < 2; c++) begin
        if (!dwait[c]) got_ack(c, 1'b1);
        if (!iwait[c]) got_ack(c, 1'b0);
      end
    end
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic mid();
    @(negedge CLK);
  endtask
  initial begin
    iREN = 2'b11;
    dREN = 2'b11;
    tick();
    tick();
    mid();
    cmp("rst_waits", {iwait, dwait}, 4'hF);
    cmp("rst_ram_en", {ramREN, ramWEN}, 2'b00);
    cmp("rst_ramaddr", ramaddr, 0);
    cmp("rst_ramstore", ramstore, 0);
    tick();
    nRST = 1'b1;
    iREN = '0;
    dREN = '0;
    tick();
    dREN[0] = 1'b1;
    daddr[0] = 32'h40;
    push(0, 1, 0, 32'h40, 0);
    mid();
    cmp("single_idle_ramREN", ramREN, 0);
    tick();
    mid();
    cmp("single_ramREN", ramREN, 1);
    cmp("single_dwait", dwait, 2'b10);
    tick();
    dREN = '0;
    tick();
    ram_mode = 1;
    dREN[1] = 1'b1;
    daddr[1] = 32'h80;
    tick();
    mid();
    cmp("abort_busy_ramREN", ramREN, 1);
    tick();
    dREN[1] = 1'b0;
    mid();
    cmp("abort_dropped_ramREN", ramREN, 0);
    cmp("abort_waits", {iwait, dwait}, 4'hF);
    tick();
    mid();
    cmp("abort_idle_ramREN", ramREN, 0);
    tick();
    ram_mode = 0;
    dREN = 2'b11;
    daddr[0] = 32'h44;
    push(1, 1, 0, 32'h80, 0);
    tick();
    tick();
    dREN = '0;
    tick();
    iREN[0] = 1'b1;
    iaddr[0] = 32'h100;
    dWEN[1] = 1'b1;
    dREN[1] = 1'b1;
    daddr[1] = 32'h200;
    dstore[1] = 32'hDEAD_BEEF;
    push(1, 1, 1, 32'h200, 32'hDEAD_BEEF);
    push(0, 0, 0, 32'h100, 0);
    tick();
    tick();
    dWEN[1] = 1'b0;
    dREN[1] = 1'b0;
    tick();
    tick();
    iREN = '0;
    tick();
    dREN = 2'b11;
    daddr[0] = 32'h10;
    daddr[1] = 32'h14;
    push(0, 1, 0, 32'h10, 0);
    push(1, 1, 0, 32'h14, 0);
    push(0, 1, 0, 32'h10, 0);
    push(1, 1, 0, 32'h14, 0);
    for (int i = 0; i < 8; i++) tick();
    dREN = '0;
    tick();
    ram_mode = 2;
    dREN = 2'b11;
    tick();
    mid();
    cmp("err_ramaddr", ramaddr, 32'h10);
    cmp("err_waits", {iwait, dwait}, 4'hF);
    tick();
    ram_mode = 0;
    push(0, 1, 0, 32'h10, 0);
    mid();
    cmp("err_bubble_ramREN", ramREN, 0);
    tick();
    tick();
    dREN = '0;
    tick();
    ram_mode = 1;
    dREN[0] = 1'b1;
    tick();
    mid();
    cmp("rstg_ramREN", ramREN, 1);
    nRST = 1'b0;
    tick();
    mid();
    cmp("rstg_ram_en", {ramREN, ramWEN}, 2'b00);
    cmp("rstg_waits", {iwait, dwait}, 4'hF);
    tick();
    nRST = 1'b1;
    dREN = '0;
    ram_mode = 0;
    tick();
    dREN = 2'b11;
    push(0, 1, 0, 32'h10, 0);
    tick();
    tick();
    dREN = '0;
    tick();
    tick();
    cmp("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
